// File: rtl/board_renderer_pkg.sv
// rtl/board_renderer_pkg.sv - shared types, latency and overlay colours for the board renderer
// Contents: LAT (DrawX/DrawY to pixel latency), rgb12 colour struct, sq_t square index,
//           CURSOR_RGB / SEL_RGB overlay colours, sel_blend() half-sum tint helper.
package board_render_pkg;

  localparam int LAT = 3;

  typedef logic [2:0] sq_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12;

  localparam rgb12 CURSOR_RGB = 12'h0FF;
  localparam rgb12 SEL_RGB    = 12'h111;

  // (a+b)>>1 with a 5-bit intermediate so the sum never wraps.
  function automatic logic [3:0] half_sum(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4:1];
  endfunction

  function automatic rgb12 sel_blend(input rgb12 base);
    rgb12 o;
    o.r = half_sum(base.r, SEL_RGB.r);
    o.g = half_sum(base.g, SEL_RGB.g);
    o.b = half_sum(base.b, SEL_RGB.b);
    return o;
  endfunction

endpackage

// File: rtl/board_renderer_if.sv
// rtl/board_renderer_if.sv - texture ROM port between the renderer and an external synchronous ROM
// Signals: rom_addr (ROM_AW, renderer -> ROM), rom_q (4-bit palette index, ROM -> renderer,
//          valid one clock after rom_addr). master = renderer side, slave = ROM side.
interface board_renderer_if #(
  parameter int ROM_AW = 16
);
  logic [ROM_AW-1:0] rom_addr;
  logic [3:0]        rom_q;

  modport master (output rom_addr, input rom_q);
  modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/board_palette.sv
// rtl/board_palette.sv - combinational 16-entry palette lookup for board texels
// Ports: idx (4-bit palette index in), rgb (rgb12 colour out).
module board_palette
  import board_render_pkg::*;
(
  input  logic [3:0] idx,
  output rgb12       rgb
);

  always_comb begin
    rgb = 12'h000;
    case (idx)
      4'd0:  rgb = 12'h000;
      4'd1:  rgb = 12'hFFF;
      4'd2:  rgb = 12'hEDB;  // light square
      4'd3:  rgb = 12'h853;  // dark square
      4'd4:  rgb = 12'h420;
      4'd5:  rgb = 12'hF08;
      4'd6:  rgb = 12'h0F0;
      4'd7:  rgb = 12'h00F;
      4'd8:  rgb = 12'hF00;
      4'd9:  rgb = 12'hFF0;
      4'd10: rgb = 12'hA5A;
      4'd11: rgb = 12'hF0F;
      4'd12: rgb = 12'h888;
      4'd13: rgb = 12'h444;
      4'd14: rgb = 12'hCCC;
      4'd15: rgb = 12'h222;
      default: rgb = 12'h000;
    endcase
  end

endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - pipelined scaled board-texture renderer with cursor and selection overlays
// Ports: vga_clk/Reset (sync active-high); DrawX/DrawY scan position; cursor_col/row,
//        sel_valid/sel_col/sel_row overlay controls; rom (texture ROM port, master);
//        red/green/blue, boardon, sq_col/sq_row pixel outputs, LAT cycles after DrawX/DrawY.
module board_renderer
  import board_render_pkg::*;
#(
  parameter int BOARD_X0     = 80,
  parameter int BOARD_Y0     = 0,
  parameter int TEX_W        = 240,
  parameter int TEX_H        = 240,
  parameter int SCALE        = 2,
  parameter int N_SQ         = 8,
  parameter int OUTLINE      = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int ROM_AW       = $clog2(TEX_W*TEX_H)
) (
  input  logic             vga_clk,
  input  logic             Reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  sq_t              cursor_col,
  input  sq_t              cursor_row,
  input  logic             sel_valid,
  input  sq_t              sel_col,
  input  sq_t              sel_row,
  board_renderer_if.master rom,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             boardon,
  output sq_t              sq_col,
  output sq_t              sq_row
);

  localparam int BOARD_W  = TEX_W * SCALE;
  localparam int BOARD_H  = TEX_H * SCALE;
  localparam int SQ_PIX   = BOARD_W / N_SQ;
  localparam int SQ_PIX_Y = BOARD_H / N_SQ;
  localparam int FCW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]    X_BEG    = 11'(BOARD_X0);
  localparam logic [10:0]    Y_BEG    = 11'(BOARD_Y0);
  localparam logic [10:0]    W_LEN    = 11'(BOARD_W);
  localparam logic [10:0]    H_LEN    = 11'(BOARD_H);
  localparam logic [2:0]     SUB_LAST = 3'(SCALE - 1);
  localparam logic [9:0]     PXX_LAST = 10'(SQ_PIX - 1);
  localparam logic [9:0]     PXY_LAST = 10'(SQ_PIX_Y - 1);
  localparam logic [9:0]     OUT_LO   = 10'(OUTLINE);
  localparam logic [9:0]     OUT_HI_X = 10'(SQ_PIX - OUTLINE);
  localparam logic [9:0]     OUT_HI_Y = 10'(SQ_PIX_Y - OUTLINE);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(BLINK_FRAMES - 1);
  localparam logic [ROM_AW-1:0] ROW_STEP = ROM_AW'(TEX_W);

  // Range test as a single unsigned compare: positions left of / above the
  // board wrap to large 11-bit values and fall outside the length.
  logic [10:0] rel_x, rel_y;
  logic        in_x, in_y;
  assign rel_x = {1'b0, DrawX} - X_BEG;
  assign rel_y = {1'b0, DrawY} - Y_BEG;
  assign in_x  = rel_x < W_LEN;
  assign in_y  = rel_y < H_LEN;

  // Stage 1 state: scan counters (they double as stage-1 sideband).
  logic [2:0]        sub_x, sub_x_n, sub_y, sub_y_n;
  logic [9:0]        tex_x, tex_x_n, tex_y, tex_y_n;
  logic [9:0]        px_sq_x, px_sq_x_n, px_sq_y, px_sq_y_n;
  sq_t               col, col_n, row, row_n;
  logic [ROM_AW-1:0] row_base, row_base_n, addr_n;
  logic              rows_valid, rows_valid_n;
  logic [FCW-1:0]    frame_cnt, frame_cnt_n;
  logic              blink_on, blink_on_n;
  logic              hit_s1;

  always_comb begin
    sub_x_n   = sub_x;
    tex_x_n   = tex_x;
    px_sq_x_n = px_sq_x;
    col_n     = col;
    if (DrawX == 10'(BOARD_X0)) begin
      sub_x_n   = '0;
      tex_x_n   = '0;
      px_sq_x_n = '0;
      col_n     = '0;
    end else if (in_x) begin
      if (sub_x == SUB_LAST) begin
        sub_x_n = '0;
        tex_x_n = tex_x + 10'd1;
      end else begin
        sub_x_n = sub_x + 3'd1;
      end
      if (px_sq_x == PXX_LAST) begin
        px_sq_x_n = '0;
        col_n     = col + 3'd1;
      end else begin
        px_sq_x_n = px_sq_x + 10'd1;
      end
    end
  end

  // Row counters only move at the start of a line; outside the board rows
  // they freeze until the next BOARD_Y0 reload.
  always_comb begin
    sub_y_n      = sub_y;
    tex_y_n      = tex_y;
    row_base_n   = row_base;
    px_sq_y_n    = px_sq_y;
    row_n        = row;
    rows_valid_n = rows_valid;
    if (DrawX == 10'd0) begin
      if (DrawY == 10'(BOARD_Y0)) begin
        sub_y_n      = '0;
        tex_y_n      = '0;
        row_base_n   = '0;
        px_sq_y_n    = '0;
        row_n        = '0;
        rows_valid_n = 1'b1;
      end else if (in_y && ({1'b0, DrawY} > Y_BEG)) begin
        if (sub_y == SUB_LAST) begin
          sub_y_n    = '0;
          tex_y_n    = tex_y + 10'd1;
          row_base_n = row_base + ROW_STEP;
        end else begin
          sub_y_n = sub_y + 3'd1;
        end
        if (px_sq_y == PXY_LAST) begin
          px_sq_y_n = '0;
          row_n     = row + 3'd1;
        end else begin
          px_sq_y_n = px_sq_y + 10'd1;
        end
      end
    end
  end

  always_comb begin
    frame_cnt_n = frame_cnt;
    blink_on_n  = blink_on;
    if (DrawX == 10'd0 && DrawY == 10'd0) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt_n = '0;
        blink_on_n  = ~blink_on;
      end else begin
        frame_cnt_n = frame_cnt + 1'b1;
      end
    end
  end

  assign addr_n = (in_x && in_y) ? (row_base_n + ROM_AW'(tex_x_n)) : '0;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      sub_x        <= '0;
      tex_x        <= '0;
      px_sq_x      <= '0;
      col          <= '0;
      sub_y        <= '0;
      tex_y        <= '0;
      row_base     <= '0;
      px_sq_y      <= '0;
      row          <= '0;
      rows_valid   <= 1'b0;
      frame_cnt    <= '0;
      blink_on     <= 1'b1;
      hit_s1       <= 1'b0;
      rom.rom_addr <= '0;
    end else begin
      sub_x        <= sub_x_n;
      tex_x        <= tex_x_n;
      px_sq_x      <= px_sq_x_n;
      col          <= col_n;
      sub_y        <= sub_y_n;
      tex_y        <= tex_y_n;
      row_base     <= row_base_n;
      px_sq_y      <= px_sq_y_n;
      row          <= row_n;
      rows_valid   <= rows_valid_n;
      frame_cnt    <= frame_cnt_n;
      blink_on     <= blink_on_n;
      hit_s1       <= in_x && in_y && rows_valid_n;
      rom.rom_addr <= addr_n;
    end
  end

  // Stage 2: sideband delayed one clock to line up with rom_q.
  logic       hit_s2, blink_s2;
  sq_t        col_s2, row_s2;
  logic [9:0] pxx_s2, pxy_s2;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      hit_s2   <= 1'b0;
      blink_s2 <= 1'b1;
      col_s2   <= '0;
      row_s2   <= '0;
      pxx_s2   <= '0;
      pxy_s2   <= '0;
    end else begin
      hit_s2   <= hit_s1;
      blink_s2 <= blink_on;
      col_s2   <= col;
      row_s2   <= row;
      pxx_s2   <= px_sq_x;
      pxy_s2   <= px_sq_y;
    end
  end

  rgb12 base_rgb, pix_n;
  logic on_edge;

  board_palette u_palette (
    .idx (rom.rom_q),
    .rgb (base_rgb)
  );

  assign on_edge = (pxx_s2 < OUT_LO) || (pxx_s2 >= OUT_HI_X) ||
                   (pxy_s2 < OUT_LO) || (pxy_s2 >= OUT_HI_Y);

  // Cursor outline wins over the selection tint.
  always_comb begin
    pix_n = base_rgb;
    if (blink_s2 && on_edge && col_s2 == cursor_col && row_s2 == cursor_row) begin
      pix_n = CURSOR_RGB;
    end else if (sel_valid && col_s2 == sel_col && row_s2 == sel_row) begin
      pix_n = sel_blend(base_rgb);
    end
    if (!hit_s2) begin
      pix_n = 12'h000;
    end
  end

  // Stage 3: output registers.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      boardon <= 1'b0;
      sq_col  <= '0;
      sq_row  <= '0;
    end else begin
      red     <= pix_n.r;
      green   <= pix_n.g;
      blue    <= pix_n.b;
      boardon <= hit_s2;
      sq_col  <= hit_s2 ? col_s2 : '0;
      sq_row  <= hit_s2 ? row_s2 : '0;
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - directed self-checking bench for board_renderer
`timescale 1ns/1ps
module tb_board_renderer;
  import board_render_pkg::*;

  logic       vga_clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  sq_t        cursor_col, cursor_row, sel_col, sel_row;
  logic       sel_valid;
  logic [3:0] rom_fill;

  logic [3:0] red, green, blue, red_b, green_b, blue_b;
  logic       boardon, boardon_b;
  sq_t        sq_col, sq_row, sq_col_b, sq_row_b;

  int vectors = 0;
  int miscompares = 0;

  // Captured per column of the most recent scan.
  logic [17:0] addr_a [0:799];
  logic [17:0] addr_b [0:799];
  logic [11:0] rgb_at [0:799];
  logic        on_at  [0:799];
  sq_t         sqc_at [0:799];
  sq_t         sqr_at [0:799];

  board_renderer_if #(.ROM_AW(16)) rom_a ();
  board_renderer_if #(.ROM_AW(18)) rom_b ();

  board_renderer dut_a (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .sel_valid(sel_valid), .sel_col(sel_col), .sel_row(sel_row),
    .rom(rom_a), .red(red), .green(green), .blue(blue),
    .boardon(boardon), .sq_col(sq_col), .sq_row(sq_row)
  );

  board_renderer #(.SCALE(1), .TEX_W(480), .TEX_H(480)) dut_b (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .sel_valid(sel_valid), .sel_col(sel_col), .sel_row(sel_row),
    .rom(rom_b), .red(red_b), .green(green_b), .blue(blue_b),
    .boardon(boardon_b), .sq_col(sq_col_b), .sq_row(sq_row_b)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM models: data one clock after the address.
  always @(posedge vga_clk) begin
    rom_a.rom_q <= rom_fill;
    rom_b.rom_q <= rom_fill;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive DrawX = xa..xb+2 on line y; address captured at the edge of its
  // pixel, pixel outputs captured two edges later (LAT from drive to output).
  task automatic run(input int y, input int xa, input int xb);
    for (int x = xa; x <= xb + 2; x++) begin
      DrawX = 10'(x);
      DrawY = 10'(y);
      @(posedge vga_clk);
      #1;
      if (x <= xb) begin
        addr_a[x] = 18'(rom_a.rom_addr);
        addr_b[x] = rom_b.rom_addr;
      end
      if (x - 2 >= xa) begin
        rgb_at[x-2] = {red, green, blue};
        on_at[x-2]  = boardon;
        sqc_at[x-2] = sq_col;
        sqr_at[x-2] = sq_row;
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    DrawX = 10'd799;
    DrawY = 10'd524;
    cursor_col = 3'd0;
    cursor_row = 3'd0;
    sel_valid  = 1'b0;
    sel_col    = 3'd0;
    sel_row    = 3'd0;
    rom_fill   = 4'd2;
    repeat (2) @(posedge vga_clk);
    #1;
    chk("reset_addr",    32'(rom_a.rom_addr), 32'h0);
    chk("reset_rgb",     32'({red, green, blue}), 32'h0);
    chk("reset_boardon", 32'(boardon), 32'h0);
    chk("reset_sq",      32'({sq_col, sq_row}), 32'h0);
    Reset = 1'b0;

    // Line 0: column addressing, boardon edges, square index, cursor edge.
    run(0, 0, 0);
    run(0, 79, 560);
    chk("addr_x79",   32'(addr_a[79]),  32'd0);
    chk("addr_x80",   32'(addr_a[80]),  32'd0);
    chk("addr_x81",   32'(addr_a[81]),  32'd0);
    chk("addr_x82",   32'(addr_a[82]),  32'd1);
    chk("addr_x559",  32'(addr_a[559]), 32'd239);
    chk("addr_x560",  32'(addr_a[560]), 32'd0);
    chk("on_x79",     32'(on_at[79]),  32'd0);
    chk("on_x80",     32'(on_at[80]),  32'd1);
    chk("on_x559",    32'(on_at[559]), 32'd1);
    chk("on_x560",    32'(on_at[560]), 32'd0);
    chk("sqc_x139",   32'(sqc_at[139]), 32'd0);
    chk("sqc_x140",   32'(sqc_at[140]), 32'd1);
    chk("sqc_x559",   32'(sqc_at[559]), 32'd7);
    chk("rgb_x79",    32'(rgb_at[79]),  32'h000);
    chk("cur_80_0",   32'(rgb_at[80]),  32'h0FF);
    chk("cur_139_0",  32'(rgb_at[139]), 32'h0FF);
    chk("pal_140_0",  32'(rgb_at[140]), 32'hEDB);
    chk("b_addr_x80", 32'(addr_b[80]),  32'd0);
    chk("b_addr_x81", 32'(addr_b[81]),  32'd1);
    chk("b_addr_x559",32'(addr_b[559]), 32'd479);

    run(1, 0, 0);
    run(1, 79, 85);
    chk("b_addr_y1_x80", 32'(addr_b[80]), 32'd480);
    chk("addr_y1_x80",   32'(addr_a[80]), 32'd0);
    run(2, 0, 0);
    run(3, 0, 0);
    run(3, 79, 85);
    chk("addr_y3_x80", 32'(addr_a[80]), 32'd240);

    for (int y = 4; y <= 477; y++) begin
      run(y, 0, 0);
      if (y == 30) begin
        run(30, 79, 120);
        chk("pal_110_30", 32'(rgb_at[110]), 32'hEDB);
        chk("cur_81_30",  32'(rgb_at[81]),  32'h0FF);
        chk("sqr_110_30", 32'(sqr_at[110]), 32'd0);
      end
      if (y == 59) begin
        run(59, 79, 120);
        chk("cur_81_59", 32'(rgb_at[81]), 32'h0FF);
      end
      if (y == 60) begin
        run(60, 79, 120);
        chk("sqr_110_60", 32'(sqr_at[110]), 32'd1);
      end
    end

    // Selection tint on square (7,7), then cursor on the same square.
    rom_fill = 4'd5;
    sel_valid = 1'b1;
    sel_col = 3'd7;
    sel_row = 3'd7;
    run(478, 0, 0);
    run(478, 79, 560);
    chk("sel_530_478",  32'(rgb_at[530]), 32'h804);
    chk("base_80_478",  32'(rgb_at[80]),  32'hF08);
    chk("sqr_530_478",  32'(sqr_at[530]), 32'd7);
    run(479, 0, 0);
    cursor_col = 3'd7;
    cursor_row = 3'd7;
    run(479, 79, 560);
    chk("addr_y479_x559",   32'(addr_a[559]), 32'd57599);
    chk("b_addr_y479_x559", 32'(addr_b[559]), 32'd230399);
    chk("cur_over_sel",     32'(rgb_at[539]), 32'h0FF);

    run(480, 0, 0);
    run(480, 79, 100);
    chk("addr_y480", 32'(addr_a[80]), 32'd0);
    chk("on_y480",   32'(on_at[80]),  32'd0);

    // Blink: frame 29 still shows the cursor, frame 30 hides it.
    cursor_col = 3'd0;
    cursor_row = 3'd0;
    sel_valid = 1'b0;
    rom_fill = 4'd2;
    for (int i = 0; i < 27; i++) begin
      DrawX = 10'd0;
      DrawY = 10'd0;
      @(posedge vga_clk);
    end
    run(0, 0, 0);
    run(0, 79, 85);
    chk("blink_f29", 32'(rgb_at[80]), 32'h0FF);
    run(0, 0, 0);
    run(0, 79, 85);
    chk("blink_f30",    32'(rgb_at[80]), 32'hEDB);
    chk("blink_f30_81", 32'(rgb_at[81]), 32'hEDB);

    // Mid-frame reset at DrawY=200.
    for (int y = 1; y <= 199; y++) run(y, 0, 0);
    run(200, 0, 0);
    run(200, 79, 120);
    chk("pre_reset_on", 32'(on_at[100]), 32'd1);
    Reset = 1'b1;
    DrawX = 10'd123;
    @(posedge vga_clk);
    DrawX = 10'd124;
    @(posedge vga_clk);
    #1;
    chk("mid_reset_rgb",  32'({red, green, blue}), 32'h0);
    chk("mid_reset_on",   32'(boardon), 32'd0);
    chk("mid_reset_addr", 32'(rom_a.rom_addr), 32'd0);
    chk("mid_reset_sq",   32'({sq_col, sq_row}), 32'h0);
    Reset = 1'b0;
    run(200, 125, 560);
    chk("post_reset_on_300", 32'(on_at[300]), 32'd0);
    run(201, 0, 0);
    run(201, 79, 560);
    chk("post_reset_on_80",   32'(on_at[80]),  32'd0);
    chk("post_reset_rgb_300", 32'(rgb_at[300]), 32'h000);
    run(0, 0, 0);
    run(0, 79, 100);
    chk("next_frame_addr80", 32'(addr_a[80]), 32'd0);
    chk("next_frame_addr82", 32'(addr_a[82]), 32'd1);
    chk("next_frame_on80",   32'(on_at[80]),  32'd1);
    chk("next_frame_cur80",  32'(rgb_at[80]), 32'h0FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_renderer.md
# board_renderer

Parametrised, pipelined board-texture renderer for the VGA path. Maps the current DrawX/DrawY scan position onto a scaled board texture held in an external synchronous ROM. Addresses come from incremental counters, with no multipliers or dividers. The block overlays a blinking cursor outline and a tinted selected square, and reports which board square each output pixel belongs to. It sits between the VGA controller and the colour mux, replacing the fixed-geometry board drawer.

## Interface
- BOARD_X0, 80, first on-screen board column
- BOARD_Y0, 0, first on-screen board row
- TEX_W, 240, texture width in texels
- TEX_H, 240, texture height in texels
- SCALE, 2, screen pixels per texel per axis (1, 2 or 4)
- N_SQ, 8, squares per side; TEX_W and TEX_H divisible by N_SQ
- OUTLINE, 2, cursor outline thickness in screen pixels
- BLINK_FRAMES, 30, frames per blink phase
- ROM_AW, $clog2(TEX_W*TEX_H), ROM address width
- vga_clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high
- DrawX, DrawY  in  10 each  scan position; DrawX advances by one per vga_clk
- cursor_col, cursor_row  in  3 each  cursor square
- sel_valid  in  1  a square is selected
- sel_col, sel_row  in  3 each  selected square
- rom_addr  out  ROM_AW  texel address, registered
- rom_q  in  4  palette index, valid one cycle after rom_addr
- red, green, blue  out  4 each  pixel colour
- boardon  out  1  pixel lies on the board
- sq_col, sq_row  out  3 each  square of the current output pixel

## Operation
- Derived values: BOARD_W = TEX_W*SCALE, BOARD_H = TEX_H*SCALE, SQ_PIX = BOARD_W/N_SQ.
- in_x is true when BOARD_X0 ≤ DrawX < BOARD_X0+BOARD_W. in_y uses the same rule on the Y axis.
- Column counters: sub_x (0..SCALE-1), tex_x, px_sq_x (0..SQ_PIX-1) and col.
  - All four load 0 when DrawX==BOARD_X0.
  - Otherwise, while in_x, they step by one and wrap: tex_x increments on sub_x wrap, col increments on px_sq_x wrap.
- Row counters: sub_y, tex_y, row_base, px_sq_y and row. They update only when DrawX==0.
  - When DrawY==BOARD_Y0, all load 0 and rows_valid is set.
  - When in_y and DrawY>BOARD_Y0, they advance one pixel row. row_base increases by TEX_W each time sub_y wraps.
- rom_addr = row_base + tex_x, registered. rom_addr is held at 0 when not (in_x & in_y).
- board_hit = in_x & in_y & rows_valid. Any pixel without board_hit outputs boardon=0 and rgb=0.
- Colour: the board_palette sub-module maps rom_q to base rgb. Overlays are applied in priority order:
  - Cursor: applies when (col,row)==cursor and the pixel lies within OUTLINE of a square edge (px_sq < OUTLINE or px_sq ≥ SQ_PIX-OUTLINE on either axis) and blink_on. The colour becomes CURSOR_RGB.
  - Selected: applies when sel_valid and (col,row)==sel. Each channel becomes (base+SEL_RGB)>>1 using 5-bit intermediates, with no overflow.
  - Otherwise the colour is base rgb.
- Blink: a frame counter increments when DrawX==0 && DrawY==0. When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles blink_on.
- Cursor and selection inputs are sampled in stage 2. Changes take effect on the next pixel; there is no frame-level latching.

## Timing
- Fixed latency LAT=3 from DrawX/DrawY to red/green/blue/boardon/sq_col/sq_row, exported in the package. Downstream delays hsync/vsync by LAT.
  - Stage 1: counters, rom_addr and board_hit are registered.
  - Stage 2: rom_q is returned; overlay decision is made.
  - Stage 3: output registers.
- Sideband signals (board_hit, col, row, px_sq, blink_on) are pipelined alongside the ROM data.
- Reset values:
  - rom_addr=0, rgb=0, boardon=0, sq_col=sq_row=0.
  - All counters 0, rows_valid=0, frame counter 0, blink_on=1.
- Reset mid-frame: boardon stays 0 until DrawY==BOARD_Y0 of the next frame, because row counters are invalid until then.
- Column boundaries: the last texel of a line is at DrawX=BOARD_X0+BOARD_W-1. The next pixel has boardon=0, with no counter overrun.
- Row boundaries: row counters freeze outside in_y and are reloaded at the next BOARD_Y0.

## Structure
- Package board_render_pkg holds:
  - LAT
  - CURSOR_RGB and SEL_RGB constants
  - an rgb12 typedef (three 4-bit fields)
  - a sq_t typedef (3-bit square index)
- Sub-module board_palette: combinational, 4-bit index in, rgb12 out.

## Test plan
- Default parameters; scan the line DrawY=0, DrawX 79..560.
  - rom_addr=0 for DrawX 80 and 81, and 1 for DrawX 82.
  - rom_addr=239 for DrawX 559.
  - boardon rises 3 cycles after DrawX=80 and falls 3 cycles after DrawX=560.
- Full frame: DrawY=3, DrawX=80 gives addr 240. DrawY=479, DrawX=559 gives addr 57599. sq_col=1 first appears for DrawX=140.
- Cursor (0,0), blink_on: pixels (80,0) and (81,59) output CURSOR_RGB. Pixel (110,30) outputs the palette colour. After 30 frames, pixel (80,0) outputs the palette colour.
- sel_valid=1, sel=(7,7), palette index giving rgb (0xF,0x0,0x8), SEL_RGB=(0x1,0x1,0x1): output is (0x8,0x0,0x4). With cursor also at (7,7), an edge pixel outputs CURSOR_RGB.
- Assert Reset at DrawY=200 for 2 cycles: all outputs are 0, boardon=0 for the rest of the frame, and the next frame renders addr 0 at (80,0).
- SCALE=1, TEX_W=TEX_H=480: DrawX=81 gives addr 1, and DrawY=1, DrawX=80 gives addr 480.
